// File: rtl/monitoreo_pkg.sv
// rtl/monitoreo_pkg.sv - shared types and default parameters for the multi-channel temperature monitor
package monitoreo_pkg;

  typedef enum logic [1:0] {
    NORMAL   = 2'b00,
    FRIO     = 2'b01,
    CALIENTE = 2'b10,
    ALERTA   = 2'b11
  } estado_t;

  localparam int N_CH_DEF      = 4;
  localparam int W_DEF         = 11;
  localparam int N_PERSIST_DEF = 3;

endpackage

// File: rtl/canal_monitoreo.sv
// rtl/canal_monitoreo.sv - one channel: persistence counters, safe flag, control FSM and actuator decode
module canal_monitoreo
  import monitoreo_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int N_PERSIST = N_PERSIST_DEF,
  parameter int CW        = $clog2(N_PERSIST + 1)
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                sel,
  input  logic signed [W-1:0] temp,
  input  logic signed [W-1:0] umbral_bajo,
  input  logic signed [W-1:0] umbral_alto,
  input  logic signed [W-1:0] umbral_critico,
  input  logic        [W-2:0] histeresis,
  input  logic                ack,
  output logic        [1:0]   estado,
  output logic                calefactor,
  output logic                ventilador,
  output logic                alerta
);

  localparam logic [CW-1:0] CMAX = CW'(N_PERSIST);

  estado_t       est_q, est_d;
  logic [CW-1:0] cont_alto_q, cont_alto_d;
  logic [CW-1:0] cont_bajo_q, cont_bajo_d;
  logic          seguro_q, seguro_d;

  // One extra bit so threshold +/- hysteresis can never wrap.
  logic signed [W:0] temp_x, bajo_x, alto_x, crit_x, hist_x;
  logic signed [W:0] lim_salida_alto, lim_salida_bajo;
  logic              sobre_alto, bajo_bajo, critico, seguro_ahora, sale_frio;

  assign temp_x          = {temp[W-1], temp};
  assign bajo_x          = {umbral_bajo[W-1], umbral_bajo};
  assign alto_x          = {umbral_alto[W-1], umbral_alto};
  assign crit_x          = {umbral_critico[W-1], umbral_critico};
  assign hist_x          = {2'b00, histeresis};
  assign lim_salida_alto = alto_x - hist_x;
  assign lim_salida_bajo = bajo_x + hist_x;

  assign sobre_alto   = temp_x > alto_x;
  assign bajo_bajo    = temp_x < bajo_x;
  assign critico      = temp_x >= crit_x;
  assign seguro_ahora = temp_x <= lim_salida_alto;
  assign sale_frio    = temp_x >= lim_salida_bajo;

  function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] c);
    return (c == CMAX) ? c : c + CW'(1);
  endfunction

  always_comb begin
    cont_alto_d = cont_alto_q;
    cont_bajo_d = cont_bajo_q;
    seguro_d    = seguro_q;
    est_d       = est_q;

    if (sel) begin
      seguro_d = seguro_ahora;
      if (sobre_alto) begin
        cont_alto_d = inc_sat(cont_alto_q);
        cont_bajo_d = '0;
      end else if (bajo_bajo) begin
        cont_bajo_d = inc_sat(cont_bajo_q);
        cont_alto_d = '0;
      end else begin
        cont_alto_d = '0;
        cont_bajo_d = '0;
      end
    end

    // The ack only counts on the edge it is present, using this edge's safe flag.
    if (sel && critico) begin
      est_d = ALERTA;
    end else if (est_q == ALERTA) begin
      if (ack && seguro_d) est_d = NORMAL;
    end else if (sel) begin
      case (est_q)
        NORMAL: begin
          if (cont_alto_d == CMAX)      est_d = CALIENTE;
          else if (cont_bajo_d == CMAX) est_d = FRIO;
        end
        CALIENTE: if (seguro_ahora) est_d = NORMAL;
        FRIO:     if (sale_frio)    est_d = NORMAL;
        default:  est_d = est_q;
      endcase
    end

    if (est_d != est_q) begin
      cont_alto_d = '0;
      cont_bajo_d = '0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      est_q       <= NORMAL;
      cont_alto_q <= '0;
      cont_bajo_q <= '0;
      seguro_q    <= 1'b0;
    end else begin
      est_q       <= est_d;
      cont_alto_q <= cont_alto_d;
      cont_bajo_q <= cont_bajo_d;
      seguro_q    <= seguro_d;
    end
  end

  assign estado     = est_q;
  assign calefactor = (est_q == FRIO);
  assign ventilador = (est_q == CALIENTE) || (est_q == ALERTA);
  assign alerta     = (est_q == ALERTA);

endmodule

// File: rtl/monitor_temp_multicanal.sv
// rtl/monitor_temp_multicanal.sv - multi-channel temperature monitor: channel decode, per-channel monitors, global alarm
module monitor_temp_multicanal
  import monitoreo_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int W         = W_DEF,
  parameter int N_PERSIST = N_PERSIST_DEF,
  parameter int CW        = $clog2(N_PERSIST + 1),
  localparam int CHW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                muestra_valida,
  input  logic [CHW-1:0]      canal,
  input  logic signed [W-1:0] temp_entrada,
  input  logic signed [W-1:0] umbral_bajo,
  input  logic signed [W-1:0] umbral_alto,
  input  logic signed [W-1:0] umbral_critico,
  input  logic [W-2:0]        histeresis,
  input  logic [N_CH-1:0]     ack_alerta,
  output logic [2*N_CH-1:0]   estado,
  output logic [N_CH-1:0]     calefactor,
  output logic [N_CH-1:0]     ventilador,
  output logic [N_CH-1:0]     alerta,
  output logic                alerta_global,
  output logic                err_canal
);

  logic [N_CH-1:0] sel;
  logic            canal_invalido;

  // Only matters when N_CH is not a power of two (or is 1).
  assign canal_invalido = (32'(canal) >= N_CH);

  for (genvar c = 0; c < N_CH; c++) begin : g_canal
    assign sel[c] = muestra_valida && (canal == CHW'(c));

    canal_monitoreo #(
      .W         (W),
      .N_PERSIST (N_PERSIST),
      .CW        (CW)
    ) u_canal (
      .clk            (clk),
      .arst_n         (arst_n),
      .sel            (sel[c]),
      .temp           (temp_entrada),
      .umbral_bajo    (umbral_bajo),
      .umbral_alto    (umbral_alto),
      .umbral_critico (umbral_critico),
      .histeresis     (histeresis),
      .ack            (ack_alerta[c]),
      .estado         (estado[2*c +: 2]),
      .calefactor     (calefactor[c]),
      .ventilador     (ventilador[c]),
      .alerta         (alerta[c])
    );
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) err_canal <= 1'b0;
    else         err_canal <= muestra_valida && canal_invalido;
  end

  assign alerta_global = |alerta;

endmodule

// File: doc/monitor_temp_multicanal.md
# monitor_temp_multicanal

Parametrised multi-channel temperature monitor. It accepts time-multiplexed signed temperature samples tagged with a channel index. For each channel it keeps persistence counters, a four-state control FSM and a sticky critical alarm. It drives per-channel heater, fan and alarm outputs, and generalises the single-channel monitor with configurable thresholds, hysteresis, depth and channel count.

## Interface
Parameters:
- `N_CH`, 4: number of channels (1..16).
- `W`, 11: sample and threshold width, signed two's complement.
- `N_PERSIST`, 3: consecutive out-of-band samples needed to leave NORMAL (1..7).
- `CW`, `$clog2(N_PERSIST+1)`: counter width (derived, not overridden).

Ports:
- Clock and reset: one clock `clk`; reset `arst_n` is asynchronous and active-low.
- `clk`, in, 1: clock; all state updates on rising edge.
- `arst_n`, in, 1: asynchronous active-low reset.
- `muestra_valida`, in, 1: sample strobe.
- `canal`, in, `$clog2(N_CH)` (min 1): channel index of the sample.
- `temp_entrada`, in, W signed: sample value.
- `umbral_bajo`, `umbral_alto`, `umbral_critico`, in, W signed each: thresholds. Static config; `umbral_bajo < umbral_alto < umbral_critico`.
- `histeresis`, in, W-1 unsigned: exit hysteresis.
- `ack_alerta`, in, N_CH: per-channel alarm acknowledge.
- `estado`, out, 2*N_CH: packed per-channel state, channel c at `[2c+1:2c]`.
- `calefactor`, `ventilador`, `alerta`, out, N_CH each: per-channel actuators.
- `alerta_global`, out, 1: OR of `alerta`.
- `err_canal`, out, 1: one-cycle pulse when a valid sample's `canal >= N_CH`.

## Operation
- States, per channel: NORMAL=00, FRIO=01, CALIENTE=10, ALERTA=11.
- A sample is processed only on the channel addressed by `canal` when `muestra_valida=1`. Other channels hold all state.
- Counter update on the addressed channel. Counters saturate at `N_PERSIST`.
  - `temp > umbral_alto`: `cont_alto++`, `cont_bajo=0`.
  - `temp < umbral_bajo`: `cont_bajo++`, `cont_alto=0`.
  - Otherwise both counters are set to 0.
- Transitions are evaluated on the same edge using the updated counters. Priority is top-down:
  1. Any state goes to ALERTA if `temp >= umbral_critico`. This takes a single sample; persistence does not apply.
  2. NORMAL goes to CALIENTE when `cont_alto` reaches `N_PERSIST`.
  3. NORMAL goes to FRIO when `cont_bajo` reaches `N_PERSIST`.
  4. CALIENTE goes to NORMAL when `temp <= umbral_alto - histeresis`.
  5. FRIO goes to NORMAL when `temp >= umbral_bajo + histeresis`.
  - There is no direct transition between FRIO and CALIENTE.
- Both counters clear on every state change.
- Per-channel flag `seguro` is rewritten on each sample to `(temp <= umbral_alto - histeresis)`.
- ALERTA is sticky. ALERTA goes to NORMAL only on an edge where `ack_alerta[c]=1` and `seguro` is 1. `seguro` is evaluated including a sample arriving on that same edge. Otherwise the ack is ignored and is not remembered.
- If a critical sample and an ack arrive together, the critical sample wins and the channel stays in ALERTA.
- Arithmetic: threshold ± hysteresis and all comparisons are done on W+1-bit sign-extended operands. There is no overflow or wrap.
- Output decode from the state registers:
  - `calefactor` = FRIO.
  - `ventilador` = CALIENTE or ALERTA.
  - `alerta` = ALERTA.
- Invalid channel: the sample is dropped, no state changes, and `err_canal` pulses.
- Reset values: all `estado` = NORMAL, counters 0, `seguro` 0, and all outputs 0 including `err_canal`.

## Timing
- Outputs reflect the sample one cycle after the strobe edge. `estado` and actuators are valid after the edge that captures the sample.
- Back-to-back samples are accepted every cycle, to any channel.
- `err_canal` is registered: high for the cycle after the offending strobe.
- Reset asserted mid-operation forces reset values asynchronously. The first sample is accepted on the first rising edge after deassertion.

## Structure
- Package `monitoreo_pkg`:
  - `estado_t` enum (2-bit encodings above).
  - Default parameter constants.
- Sub-module `canal_monitoreo`:
  - Holds one channel's counters, `seguro`, FSM and decode.
  - Instantiated N_CH times by generate, with a per-channel `sel` = valid & (`canal`==c).
- Top level holds:
  - the channel decode;
  - the `err_canal` register;
  - the `alerta_global` OR.

## Test plan
Bench configuration: N_CH=4, W=11, N_PERSIST=3, bajo=15, alto=30, crit=45, hist=2.

- Reset, then 31,31,31 on ch1 -> ch1 CALIENTE and `ventilador[1]`=1 after the third sample. Other channels stay NORMAL.
- 31,31,20,31,31 on ch0 -> still NORMAL (counter cleared by 20). Then 28 on a CALIENTE channel -> NORMAL, while 29 keeps CALIENTE.
- 10,10,10 on ch2 -> FRIO and `calefactor[2]`=1. Then 16 -> stays FRIO. Then 17 -> NORMAL.
- 50 on ch3 -> ALERTA and `alerta_global`=1 after one sample. Ack with last sample 40 -> stays ALERTA. Sample 25 plus ack on the same cycle -> NORMAL.
- Ack together with a 45 sample on an ALERTA channel -> stays ALERTA. Interleaved samples to ch0..3 every cycle -> each channel tracks independently.
- Extremes: `temp=-1024`, `umbral_bajo=-1024`, `hist=1023` -> no wrap in comparisons. Reset asserted while ch1 is CALIENTE -> all outputs 0 immediately. With N_CH=3, `canal=3` -> `err_canal` pulses and there is no state change.
